// File: rtl/modbus_reg_mirror.sv
// Modbus RTU master-side register mirror: pairs each 03/06 request with its response,
// verifies CRC and header fields, and updates a bank of 16-bit shadow registers.
module modbus_reg_mirror #(
  parameter int unsigned BASE_ADDR   = 310,
  parameter int unsigned NUM_REGS    = 10,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter bit          CHECK_CRC   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tx_valid,
  input  logic [47:0]             tx_msg,
  input  logic                    rx_valid,
  input  logic [63:0]             rx_frame,
  output logic                    busy,
  output logic [16*NUM_REGS-1:0]  reg_bank,
  output logic [NUM_REGS-1:0]     reg_upd,
  output logic                    done,
  output logic [2:0]              status,
  output logic [15:0]             crc_err_cnt,
  output logic [15:0]             timeout_cnt
);

  typedef enum logic [1:0] {StIdle, StWaitRsp, StCrc, StCheck} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             req_q, req_d;
  logic                    in_range_q, in_range_d;
  logic [31:0]             idx_q, idx_d;
  logic [63:0]             rsp_q, rsp_d;
  logic [15:0]             crc_q, crc_d;
  logic [2:0]              byte_cnt_q, byte_cnt_d;
  logic [31:0]             tmo_q, tmo_d;
  logic [16*NUM_REGS-1:0]  bank_q, bank_d;
  logic [NUM_REGS-1:0]     upd_q, upd_d;
  logic                    done_q, done_d;
  logic [2:0]              status_q, status_d;
  logic [15:0]             crc_cnt_q, crc_cnt_d;
  logic [15:0]             tmo_cnt_q, tmo_cnt_d;

  logic [31:0] tx_addr;
  logic [7:0]  cur_byte;
  logic [2:0]  chk_status;
  logic [15:0] chk_data;

  // Request write value is never compared; the echoed value in the response is used.
  logic unused_tx_value;
  assign unused_tx_value = ^tx_msg[47:32];

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign tx_addr  = {16'h0000, tx_msg[23:16], tx_msg[31:24]};
  assign cur_byte = rsp_q[{byte_cnt_q, 3'b000} +: 8];

  // Response validation in priority order; data is only meaningful when status is 0.
  always_comb begin
    chk_status = 3'd0;
    chk_data   = 16'h0000;
    if (CHECK_CRC && (crc_q != rsp_q[63:48])) begin
      chk_status = 3'd1;
    end else if (rsp_q[7:0] != req_q[7:0]) begin
      chk_status = 3'd2;
    end else if (rsp_q[15:8] == (req_q[15:8] | 8'h80)) begin
      chk_status = 3'd3;
    end else if (rsp_q[15:8] != req_q[15:8]) begin
      chk_status = 3'd2;
    end else if ((req_q[15:8] == 8'h06) &&
                 ({rsp_q[23:16], rsp_q[31:24]} != {req_q[23:16], req_q[31:24]})) begin
      chk_status = 3'd2;
    end else if (!in_range_q) begin
      chk_status = 3'd5;
    end else if (req_q[15:8] == 8'h03) begin
      if (rsp_q[23:16] != 8'h02) begin
        chk_status = 3'd2;
      end else begin
        chk_data = {rsp_q[31:24], rsp_q[39:32]};
      end
    end else begin
      chk_data = {rsp_q[39:32], rsp_q[47:40]};
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    in_range_d = in_range_q;
    idx_d      = idx_q;
    rsp_d      = rsp_q;
    crc_d      = crc_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    bank_d     = bank_q;
    upd_d      = '0;
    done_d     = 1'b0;
    status_d   = status_q;
    crc_cnt_d  = crc_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (tx_valid && ((tx_msg[15:8] == 8'h03) || (tx_msg[15:8] == 8'h06))) begin
          req_d      = tx_msg[31:0];
          in_range_d = (tx_addr >= BASE_ADDR) && (tx_addr < BASE_ADDR + NUM_REGS);
          idx_d      = tx_addr - BASE_ADDR;
          tmo_d      = '0;
          state_d    = StWaitRsp;
        end
      end
      StWaitRsp: begin
        // A response arriving on the expiry cycle takes precedence over the timeout.
        if (rx_valid) begin
          rsp_d      = rx_frame;
          crc_d      = 16'hFFFF;
          byte_cnt_d = '0;
          state_d    = StCrc;
        end else if (tmo_q == TIMEOUT_CYC - 1) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          status_d = 3'd4;
          if (tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StCrc: begin
        crc_d      = crc_step(crc_q, cur_byte);
        byte_cnt_d = byte_cnt_q + 3'd1;
        if (byte_cnt_q == 3'd5) state_d = StCheck;
      end
      StCheck: begin
        state_d  = StIdle;
        done_d   = 1'b1;
        status_d = chk_status;
        if (chk_status == 3'd0) begin
          for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (idx_q == 32'(i)) begin
              bank_d[16*i +: 16] = chk_data;
              upd_d[i]           = 1'b1;
            end
          end
        end
        if ((chk_status == 3'd1) && (crc_cnt_q != 16'hFFFF)) crc_cnt_d = crc_cnt_q + 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      req_q      <= '0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      rsp_q      <= '0;
      crc_q      <= 16'hFFFF;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
      bank_q     <= '0;
      upd_q      <= '0;
      done_q     <= 1'b0;
      status_q   <= 3'd0;
      crc_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      in_range_q <= in_range_d;
      idx_q      <= idx_d;
      rsp_q      <= rsp_d;
      crc_q      <= crc_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      bank_q     <= bank_d;
      upd_q      <= upd_d;
      done_q     <= done_d;
      status_q   <= status_d;
      crc_cnt_q  <= crc_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign reg_bank    = bank_q;
  assign reg_upd     = upd_q;
  assign done        = done_q;
  assign status      = status_q;
  assign crc_err_cnt = crc_cnt_q;
  assign timeout_cnt = tmo_cnt_q;

endmodule

// File: tb/tb_modbus_reg_mirror.sv
// Directed bench for modbus_reg_mirror: two instances sharing stimulus, one with CRC
// checking disabled; expected values come from hand-built vectors and a CRC-16 model.
module tb_modbus_reg_mirror;

  localparam int unsigned NR = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tx_valid = 1'b0;
  logic [47:0]     tx_msg = '0;
  logic            rx_valid = 1'b0;
  logic [63:0]     rx_frame = '0;

  logic            busy, done, nc_busy, nc_done;
  logic [16*NR-1:0] reg_bank, nc_bank;
  logic [NR-1:0]   reg_upd, nc_upd;
  logic [2:0]      status, nc_status;
  logic [15:0]     crc_err_cnt, timeout_cnt, nc_crc_cnt, nc_tmo_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [16*NR-1:0] exp_bank = '0;

  always #5 clk = ~clk;

  modbus_reg_mirror #(
    .BASE_ADDR(310), .NUM_REGS(NR), .TIMEOUT_CYC(20), .CHECK_CRC(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_msg(tx_msg),
    .rx_valid(rx_valid), .rx_frame(rx_frame), .busy(busy), .reg_bank(reg_bank),
    .reg_upd(reg_upd), .done(done), .status(status), .crc_err_cnt(crc_err_cnt),
    .timeout_cnt(timeout_cnt)
  );

  modbus_reg_mirror #(
    .BASE_ADDR(310), .NUM_REGS(NR), .TIMEOUT_CYC(20), .CHECK_CRC(1'b0)
  ) dut_nc (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_msg(tx_msg),
    .rx_valid(rx_valid), .rx_frame(rx_frame), .busy(nc_busy), .reg_bank(nc_bank),
    .reg_upd(nc_upd), .done(nc_done), .status(nc_status), .crc_err_cnt(nc_crc_cnt),
    .timeout_cnt(nc_tmo_cnt)
  );

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc16(input logic [47:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      c ^= {8'h00, d[8*i +: 8]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [63:0] rsp(input logic [7:0] b0, b1, b2, b3, b4, b5);
    logic [47:0] d;
    d = {b5, b4, b3, b2, b1, b0};
    return {crc16(d), d};
  endfunction

  function automatic logic [47:0] req(input logic [7:0] func, input logic [15:0] addr,
                                      input logic [15:0] val);
    return {val, addr[7:0], addr[15:8], func, 8'h01};
  endfunction

  // Request at T, response at R = T+1, results checked at R+8.
  task automatic txn(input string tag, input logic [47:0] rq, input logic [63:0] frame,
                     input logic [2:0] exp_status, input logic [NR-1:0] exp_upd);
    tx_valid = 1'b1;
    tx_msg   = rq;
    tick();
    tx_valid = 1'b0;
    check_eq({tag, ".busy_rise"}, busy, 1);
    rx_valid = 1'b1;
    rx_frame = frame;
    tick();
    rx_valid = 1'b0;
    repeat (6) tick();
    check_eq({tag, ".done_early"}, done, 0);
    tick();
    check_eq({tag, ".done"}, done, 1);
    check_eq({tag, ".busy_fall"}, busy, 0);
    check_eq({tag, ".status"}, status, exp_status);
    check_eq({tag, ".upd"}, reg_upd, exp_upd);
    check_eq({tag, ".bank"}, reg_bank, exp_bank);
  endtask

  initial begin
    int seen;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.upd", reg_upd, 0);
    check_eq("rst.status", status, 0);
    check_eq("rst.bank", reg_bank, 0);
    check_eq("rst.cnts", {crc_err_cnt, timeout_cnt}, 0);

    exp_bank[0 +: 16] = 16'h1234;
    txn("read310", req(8'h03, 16'd310, 16'h0000),
        rsp(8'h01, 8'h03, 8'h02, 8'h12, 8'h34, 8'h00), 3'd0, 10'h001);
    tick();
    check_eq("read310.done_clr", done, 0);
    check_eq("read310.upd_clr", reg_upd, 0);
    check_eq("read310.status_hold", status, 0);

    exp_bank[16*7 +: 16] = 16'h00AA;
    txn("write317", req(8'h06, 16'd317, 16'h00AA),
        rsp(8'h01, 8'h06, 8'h01, 8'h3D, 8'h00, 8'hAA), 3'd0, 10'h080);
    txn("write_badecho", req(8'h06, 16'd317, 16'h00BB),
        rsp(8'h01, 8'h06, 8'h01, 8'h3E, 8'h00, 8'hBB), 3'd2, 10'h000);

    txn("badcrc", req(8'h03, 16'd312, 16'h0000),
        rsp(8'h01, 8'h03, 8'h02, 8'h56, 8'h78, 8'h00) ^ (64'h1 << 48), 3'd1, 10'h000);
    check_eq("badcrc.cnt", crc_err_cnt, 1);
    check_eq("nocrc.status", nc_status, 0);
    check_eq("nocrc.upd", nc_upd, 10'h004);
    check_eq("nocrc.bank2", nc_bank[16*2 +: 16], 16'h5678);

    txn("exception", req(8'h03, 16'd311, 16'h0000),
        rsp(8'h01, 8'h83, 8'h02, 8'h00, 8'h00, 8'h00), 3'd3, 10'h000);
    txn("range320", req(8'h03, 16'd320, 16'h0000),
        rsp(8'h01, 8'h03, 8'h02, 8'h11, 8'h11, 8'h00), 3'd5, 10'h000);
    txn("badslave", req(8'h03, 16'd313, 16'h0000),
        rsp(8'h02, 8'h03, 8'h02, 8'h22, 8'h22, 8'h00), 3'd2, 10'h000);

    // Timeout: busy rises at T+1, done at T+21.
    tx_valid = 1'b1;
    tx_msg   = req(8'h03, 16'd311, 16'h0000);
    tick();
    tx_valid = 1'b0;
    repeat (19) tick();
    check_eq("tmo.done_early", done, 0);
    check_eq("tmo.busy_hold", busy, 1);
    tick();
    check_eq("tmo.done", done, 1);
    check_eq("tmo.status", status, 4);
    check_eq("tmo.cnt", timeout_cnt, 1);
    check_eq("tmo.busy_fall", busy, 0);

    // Response on the expiry cycle (T+20) wins over the timeout.
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (19) tick();
    rx_valid = 1'b1;
    rx_frame = rsp(8'h01, 8'h03, 8'h02, 8'hAB, 8'hCD, 8'h00);
    tick();
    rx_valid = 1'b0;
    repeat (7) tick();
    exp_bank[16*1 +: 16] = 16'hABCD;
    check_eq("expiry.done", done, 1);
    check_eq("expiry.status", status, 0);
    check_eq("expiry.bank", reg_bank, exp_bank);
    check_eq("expiry.tmo_cnt", timeout_cnt, 1);

    // Back-to-back request in the done cycle; second tx while busy is dropped.
    tx_valid = 1'b1;
    tx_msg   = req(8'h03, 16'd310, 16'h0000);
    tick();
    check_eq("b2b.busy", busy, 1);
    tx_msg = req(8'h06, 16'd311, 16'h5555);
    tick();
    tx_valid = 1'b0;
    rx_valid = 1'b1;
    rx_frame = rsp(8'h01, 8'h03, 8'h02, 8'h0F, 8'h0E, 8'h00);
    tick();
    rx_valid = 1'b0;
    repeat (7) tick();
    exp_bank[0 +: 16] = 16'h0F0E;
    check_eq("drop_tx.status", status, 0);
    check_eq("drop_tx.upd", reg_upd, 10'h001);
    check_eq("drop_tx.bank", reg_bank, exp_bank);

    // rx in IDLE and unsupported function code are both ignored.
    tick();
    rx_valid = 1'b1;
    rx_frame = rsp(8'h01, 8'h03, 8'h02, 8'h99, 8'h99, 8'h00);
    tx_valid = 1'b1;
    tx_msg   = req(8'h10, 16'd310, 16'h0000);
    tick();
    rx_valid = 1'b0;
    tx_valid = 1'b0;
    check_eq("drop_idle.busy", busy, 0);
    seen = 0;
    repeat (9) begin
      tick();
      if (done) seen++;
    end
    check_eq("drop_idle.no_done", seen, 0);
    check_eq("drop_idle.bank", reg_bank, exp_bank);

    // Reset in cycle R+3 aborts the transaction.
    tx_valid = 1'b1;
    tx_msg   = req(8'h03, 16'd312, 16'h0000);
    tick();
    tx_valid = 1'b0;
    rx_valid = 1'b1;
    rx_frame = rsp(8'h01, 8'h03, 8'h02, 8'h44, 8'h44, 8'h00);
    tick();
    rx_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_bank = '0;
    check_eq("rstmid.busy", busy, 0);
    check_eq("rstmid.bank", reg_bank, exp_bank);
    check_eq("rstmid.cnts", {crc_err_cnt, timeout_cnt}, 0);
    check_eq("rstmid.status", status, 0);
    seen = 0;
    repeat (6) begin
      tick();
      if (done || (reg_upd != 0)) seen++;
    end
    check_eq("rstmid.no_done", seen, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
